// File: rtl/exu_wb_queue_if.sv
// GPR write channel: one write per cycle, no back-pressure (the GPR file always accepts).
interface exu_gpr_w_if_t #(
    parameter int RV_GPR_AW = 5,
    parameter int RV_XLEN   = 32
);
    logic                 wen;
    logic [RV_GPR_AW-1:0] addr;
    logic [RV_XLEN-1:0]   data;

    modport mst (output wen, output addr, output data);
    modport slv (input  wen, input  addr, input  data);
endinterface

// File: rtl/exu_wb_queue.sv
// Writeback queue: merges ALU and LSU results into an in-order FIFO that
// drains one entry per cycle to the GPR write port, and offers two busy
// lookups so operand read can stall on pending destination registers.
module exu_wb_queue #(
    parameter int  DEPTH     = 4,
    parameter int  RV_GPR_AW = 5,
    parameter int  RV_XLEN   = 32,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_vld,
    output logic                 alu_rdy,
    input  logic [RV_GPR_AW-1:0] alu_rd,
    input  logic [RV_XLEN-1:0]   alu_data,
    input  logic                 lsu_vld,
    output logic                 lsu_rdy,
    input  logic [RV_GPR_AW-1:0] lsu_rd,
    input  logic [RV_XLEN-1:0]   lsu_data,
    exu_gpr_w_if_t.mst           gpr_w_mst,
    input  logic [RV_GPR_AW-1:0] chk_r1_addr,
    output logic                 chk_r1_busy,
    input  logic [RV_GPR_AW-1:0] chk_r2_addr,
    output logic                 chk_r2_busy,
    output logic [CW-1:0]        cnt,
    output logic                 empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RV_GPR_AW-1:0] r_rd   [DEPTH];
    logic [RV_XLEN-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_cnt;

    logic                 w_pop;
    logic [CW:0]          w_free;
    logic                 w_lsu_enq;
    logic                 w_alu_enq;
    logic [1:0]           w_n_enq;
    logic [PW-1:0]        w_alu_slot;

    // The head drains every cycle the queue holds anything; the drained slot
    // is reusable in the same cycle, hence the +1 on free.
    assign w_pop  = ~rst & (r_cnt != '0);
    assign w_free = (CW+1)'(DEPTH) - {1'b0, r_cnt} + {{CW{1'b0}}, w_pop};

    // LSU owns the last free slot so loads are never starved by the ALU.
    assign lsu_rdy = ~rst & (w_free >= (CW+1)'(1));
    assign alu_rdy = ~rst & ((w_free >= (CW+1)'(2)) | ((w_free == (CW+1)'(1)) & ~lsu_vld));

    // Writes to x0 are accepted but never occupy a slot.
    assign w_lsu_enq  = lsu_vld & lsu_rdy & (lsu_rd != '0);
    assign w_alu_enq  = alu_vld & alu_rdy & (alu_rd != '0);
    assign w_n_enq    = {1'b0, w_lsu_enq} + {1'b0, w_alu_enq};
    // The LSU result is older, so it takes the lower slot when both enqueue.
    assign w_alu_slot = r_wr_ptr + PW'(w_lsu_enq);

    assign gpr_w_mst.wen  = w_pop;
    assign gpr_w_mst.addr = w_pop ? r_rd[r_rd_ptr]   : '0;
    assign gpr_w_mst.data = w_pop ? r_data[r_rd_ptr] : '0;

    assign cnt   = rst ? '0 : r_cnt;
    assign empty = (cnt == '0);

    // Busy lookup over all valid entries, head included (its write is not yet visible).
    always_comb begin
        chk_r1_busy = 1'b0;
        chk_r2_busy = 1'b0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && (r_rd[i] == chk_r1_addr) && (chk_r1_addr != '0))
                    chk_r1_busy = 1'b1;
                if (r_vld[i] && (r_rd[i] == chk_r2_addr) && (chk_r2_addr != '0))
                    chk_r2_busy = 1'b1;
            end
        end
    end

    // Control state: pointers, occupancy and per-entry valid bits; a set overrides a same-slot clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_vld    <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_lsu_enq)
                r_vld[r_wr_ptr] <= 1'b1;
            if (w_alu_enq)
                r_vld[w_alu_slot] <= 1'b1;
            r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
            r_cnt    <= r_cnt + CW'(w_n_enq) - CW'(w_pop);
        end
    end

    // Entry payloads are written on enqueue only and carry no reset.
    always_ff @(posedge clk) begin
        if (w_lsu_enq) begin
            r_rd[r_wr_ptr]   <= lsu_rd;
            r_data[r_wr_ptr] <= lsu_data;
        end
        if (w_alu_enq) begin
            r_rd[w_alu_slot]   <= alu_rd;
            r_data[w_alu_slot] <= alu_data;
        end
    end
endmodule

// File: tb/tb_exu_wb_queue.sv
// Testbench for exu_wb_queue: directed scenarios plus randomized traffic
// against a queue-based reference model of the writeback queue.
module tb_exu_wb_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        alu_vld, lsu_vld;
    logic        alu_rdy, lsu_rdy;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic [4:0]  chk_r1_addr, chk_r2_addr;
    logic        chk_r1_busy, chk_r2_busy;
    logic [CW-1:0] cnt;
    logic        empty;

    exu_gpr_w_if_t gpr_if ();

    exu_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_vld    (alu_vld),
        .alu_rdy    (alu_rdy),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_vld    (lsu_vld),
        .lsu_rdy    (lsu_rdy),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .gpr_w_mst  (gpr_if),
        .chk_r1_addr(chk_r1_addr),
        .chk_r1_busy(chk_r1_busy),
        .chk_r2_addr(chk_r2_addr),
        .chk_r2_busy(chk_r2_busy),
        .cnt        (cnt),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    ent_t        mq[$];
    logic [31:0] m_gpr   [32];
    logic [31:0] dut_gpr [32];

    // Reference model: slots available this cycle (drain frees one).
    function automatic int m_free();
        return DEPTH - mq.size() + ((mq.size() != 0) ? 1 : 0);
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    // Called at the negedge: records the DUT's write, then advances the model across the next posedge.
    task automatic tick();
        bit lf, af, r;
        int fr;
        logic [4:0]  lr, ar;
        logic [31:0] ld, ad;
        if (gpr_if.wen) begin
            dut_gpr[gpr_if.addr] = gpr_if.data;
            n_wr++;
        end
        fr = m_free();
        r  = rst;
        lf = !rst && lsu_vld && (fr >= 1);
        af = !rst && alu_vld && ((fr >= 2) || (fr == 1 && !lsu_vld));
        lr = lsu_rd; ld = lsu_data; ar = alu_rd; ad = alu_data;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) begin
                m_gpr[mq[0].rd] = mq[0].data;
                void'(mq.pop_front());
            end
            if (lf && lr != 0) mq.push_back('{rd: lr, data: ld});
            if (af && ar != 0) mq.push_back('{rd: ar, data: ad});
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_vld = av; alu_rd = ar; alu_data = ad;
        lsu_vld = lv; lsu_rd = lr; lsu_data = ld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        chk_r1_addr = 5'd5; chk_r2_addr = 5'd3;
        drive(1, 5'd5, 32'h1, 1, 5'd3, 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec += 6;
            if (alu_rdy !== 1'b0) begin n_err++; $display("FAIL reset_alu_rdy: got %0b want 0", alu_rdy); end
            if (lsu_rdy !== 1'b0) begin n_err++; $display("FAIL reset_lsu_rdy: got %0b want 0", lsu_rdy); end
            if (gpr_if.wen !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %0b want 0", gpr_if.wen); end
            if (cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
            if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %0b want 1", empty); end
            if ({chk_r1_busy, chk_r2_busy} !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b want 00", {chk_r1_busy, chk_r2_busy}); end
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec += 3;
        if (gpr_if.wen !== 1'b0 || gpr_if.addr !== 5'd0 || gpr_if.data !== 32'd0) begin
            n_err++; $display("FAIL post_reset_wr: got wen=%0b addr=%0d data=%0h want 0/0/0", gpr_if.wen, gpr_if.addr, gpr_if.data);
        end
        if (cnt !== '0) begin n_err++; $display("FAIL post_reset_cnt: got %0d want 0", cnt); end
        if (lsu_rdy !== 1'b1) begin n_err++; $display("FAIL post_reset_lsu_rdy: got %0b want 1", lsu_rdy); end
        tick();
    endtask

    task automatic test_single_alu();
        chk_r1_addr = 5'd5;
        drive(1, 5'd5, 32'h1234, 0, 0, 0);
        @(negedge clk);
        n_vec += 2;
        if (alu_rdy !== 1'b1) begin n_err++; $display("FAIL single_alu_rdy: got %0b want 1", alu_rdy); end
        if (chk_r1_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_early: got %0b want 0", chk_r1_busy); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec += 4;
        if (gpr_if.wen !== 1'b1) begin n_err++; $display("FAIL single_wen: got %0b want 1", gpr_if.wen); end
        if (gpr_if.addr !== 5'd5) begin n_err++; $display("FAIL single_addr: got %0d want 5", gpr_if.addr); end
        if (gpr_if.data !== 32'h1234) begin n_err++; $display("FAIL single_data: got %0h want 1234", gpr_if.data); end
        if (chk_r1_busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %0b want 1", chk_r1_busy); end
        tick();
        @(negedge clk);
        n_vec += 2;
        if (chk_r1_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_clear: got %0b want 0", chk_r1_busy); end
        if (gpr_if.wen !== 1'b0) begin n_err++; $display("FAIL single_wen_clear: got %0b want 0", gpr_if.wen); end
        tick();
    endtask

    task automatic test_dual_issue();
        drive(1, 5'd3, 32'hBBBB, 1, 5'd3, 32'hAAAA);
        @(negedge clk);
        n_vec += 1;
        if ({lsu_rdy, alu_rdy} !== 2'b11) begin n_err++; $display("FAIL dual_rdy: got %b want 11", {lsu_rdy, alu_rdy}); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec += 2;
        if (cnt !== CW'(2)) begin n_err++; $display("FAIL dual_cnt: got %0d want 2", cnt); end
        if (gpr_if.addr !== 5'd3 || gpr_if.data !== 32'hAAAA) begin
            n_err++; $display("FAIL dual_first: got x%0d=%0h want x3=aaaa", gpr_if.addr, gpr_if.data);
        end
        tick();
        @(negedge clk);
        n_vec += 1;
        if (gpr_if.addr !== 5'd3 || gpr_if.data !== 32'hBBBB) begin
            n_err++; $display("FAIL dual_second: got x%0d=%0h want x3=bbbb", gpr_if.addr, gpr_if.data);
        end
        tick();
        @(negedge clk);
        n_vec += 1;
        if (dut_gpr[3] !== 32'hBBBB) begin n_err++; $display("FAIL dual_final_x3: got %0h want bbbb", dut_gpr[3]); end
        tick();
    endtask

    task automatic test_full_arb();
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'(2*c + 2), $urandom, 1, 5'(2*c + 1), $urandom);
            @(negedge clk);
            n_vec += 1;
            if ({lsu_rdy, alu_rdy} !== 2'b11) begin n_err++; $display("FAIL fill_rdy%0d: got %b want 11", c, {lsu_rdy, alu_rdy}); end
            tick();
        end
        drive(1, 5'd8, 32'h88, 1, 5'd7, 32'h77);
        @(negedge clk);
        n_vec += 3;
        if (cnt !== CW'(4)) begin n_err++; $display("FAIL full_cnt: got %0d want 4", cnt); end
        if (lsu_rdy !== 1'b1) begin n_err++; $display("FAIL full_lsu_rdy: got %0b want 1", lsu_rdy); end
        if (alu_rdy !== 1'b0) begin n_err++; $display("FAIL full_alu_rdy: got %0b want 0", alu_rdy); end
        tick();
        drive(1, 5'd9, 32'h99, 0, 0, 0);
        @(negedge clk);
        n_vec += 2;
        if (cnt !== CW'(4)) begin n_err++; $display("FAIL full_cnt_hold: got %0d want 4", cnt); end
        if (alu_rdy !== 1'b1) begin n_err++; $display("FAIL full_alu_alone: got %0b want 1", alu_rdy); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        n_vec += 2;
        if (cnt !== '0) begin n_err++; $display("FAIL full_drain_cnt: got %0d want 0", cnt); end
        if (dut_gpr[9] !== 32'h99) begin n_err++; $display("FAIL full_x9: got %0h want 99", dut_gpr[9]); end
        tick();
    endtask

    task automatic test_x0_drop();
        int wr0;
        wr0 = n_wr;
        chk_r2_addr = 5'd0;
        drive(1, 5'd0, 32'hFFFF, 0, 0, 0);
        @(negedge clk);
        n_vec += 2;
        if (alu_rdy !== 1'b1) begin n_err++; $display("FAIL x0_rdy: got %0b want 1", alu_rdy); end
        if (chk_r2_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %0b want 0", chk_r2_busy); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_vec += 3;
        if (cnt !== '0) begin n_err++; $display("FAIL x0_cnt: got %0d want 0", cnt); end
        if (gpr_if.wen !== 1'b0) begin n_err++; $display("FAIL x0_wen: got %0b want 0", gpr_if.wen); end
        if (chk_r2_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy_after: got %0b want 0", chk_r2_busy); end
        tick();
        n_vec += 1;
        if (n_wr !== wr0) begin n_err++; $display("FAIL x0_writes: got %0d want %0d", n_wr, wr0); end
    endtask

    task automatic test_reset_mid();
        int wr0;
        drive(1, 5'd11, 32'h11, 1, 5'd10, 32'h10);
        @(negedge clk); tick();
        drive(1, 5'd13, 32'h13, 1, 5'd12, 32'h12);
        @(negedge clk); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk_r1_addr = 5'd12; chk_r2_addr = 5'd13;
        @(negedge clk);
        n_vec += 1;
        if (cnt !== CW'(3)) begin n_err++; $display("FAIL mid_cnt_before: got %0d want 3", cnt); end
        wr0 = n_wr;
        rst = 1'b1;
        @(negedge clk);
        n_vec += 1;
        if (gpr_if.wen !== 1'b0) begin n_err++; $display("FAIL mid_wen_in_rst: got %0b want 0", gpr_if.wen); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec += 4;
        if (cnt !== '0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", cnt); end
        if (gpr_if.wen !== 1'b0) begin n_err++; $display("FAIL mid_wen: got %0b want 0", gpr_if.wen); end
        if ({chk_r1_busy, chk_r2_busy} !== 2'b00) begin n_err++; $display("FAIL mid_busy: got %b want 00", {chk_r1_busy, chk_r2_busy}); end
        if (n_wr !== wr0) begin n_err++; $display("FAIL mid_writes: got %0d want %0d", n_wr, wr0); end
        tick();
    endtask

    task automatic test_random();
        bit          e_lsu, e_alu, e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int          fr;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
            chk_r1_addr = 5'($urandom_range(0, 7));
            chk_r2_addr = 5'($urandom_range(0, 7));
            @(negedge clk);
            fr     = m_free();
            e_lsu  = !rst && (fr >= 1);
            e_alu  = !rst && ((fr >= 2) || (fr == 1 && !lsu_vld));
            e_wen  = !rst && (mq.size() > 0);
            e_addr = e_wen ? mq[0].rd : 5'd0;
            e_data = e_wen ? mq[0].data : 32'd0;
            n_vec += 8;
            if (lsu_rdy !== e_lsu) begin n_err++; $display("FAIL rnd_lsu_rdy@%0d: got %0b want %0b", c, lsu_rdy, e_lsu); end
            if (alu_rdy !== e_alu) begin n_err++; $display("FAIL rnd_alu_rdy@%0d: got %0b want %0b", c, alu_rdy, e_alu); end
            if (gpr_if.wen !== e_wen) begin n_err++; $display("FAIL rnd_wen@%0d: got %0b want %0b", c, gpr_if.wen, e_wen); end
            if (gpr_if.addr !== e_addr) begin n_err++; $display("FAIL rnd_addr@%0d: got %0d want %0d", c, gpr_if.addr, e_addr); end
            if (gpr_if.data !== e_data) begin n_err++; $display("FAIL rnd_data@%0d: got %0h want %0h", c, gpr_if.data, e_data); end
            if (cnt !== CW'(rst ? 0 : mq.size())) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, cnt, rst ? 0 : mq.size()); end
            if (chk_r1_busy !== (!rst && m_busy(chk_r1_addr))) begin
                n_err++; $display("FAIL rnd_busy1@%0d: got %0b want %0b", c, chk_r1_busy, !rst && m_busy(chk_r1_addr));
            end
            if (chk_r2_busy !== (!rst && m_busy(chk_r2_addr))) begin
                n_err++; $display("FAIL rnd_busy2@%0d: got %0b want %0b", c, chk_r2_busy, !rst && m_busy(chk_r2_addr));
            end
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < DEPTH + 2; c++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        n_vec += 1;
        if (empty !== 1'b1) begin n_err++; $display("FAIL rnd_drain_empty: got %0b want 1", empty); end
        for (int r = 0; r < 32; r++) begin
            n_vec++;
            if (dut_gpr[r] !== m_gpr[r]) begin n_err++; $display("FAIL rnd_gpr_x%0d: got %0h want %0h", r, dut_gpr[r], m_gpr[r]); end
        end
        tick();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_gpr[r]   = 32'd0;
            dut_gpr[r] = 32'd0;
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk_r1_addr = 5'd0;
        chk_r2_addr = 5'd0;
        test_reset();
        test_single_alu();
        test_dual_issue();
        test_full_arb();
        test_x0_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exu_wb_queue.md
Name: exu_wb_queue

Overview:
Writeback queue between the execution producers (ALU, LSU) and the GPR file write port. It accepts results from both producers through valid/ready handshakes and buffers them in an in-order FIFO. It drains one entry per cycle onto the GPR write channel. It also gives the operand-read stage two busy lookups, so that stage can stall on pending destination registers.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
alu_vld  input  1  ALU result valid
alu_rdy  output  1  queue can accept ALU result
alu_rd  input  RV_GPR_AW  ALU destination register
alu_data  input  RV_XLEN  ALU result
lsu_vld  input  1  LSU load result valid
lsu_rdy  output  1  queue can accept LSU result
lsu_rd  input  RV_GPR_AW  LSU destination register
lsu_data  input  RV_XLEN  load data
gpr_w_mst.wen  output  1  GPR write enable (exu_gpr_w_if_t.mst)
gpr_w_mst.addr  output  RV_GPR_AW  GPR write address
gpr_w_mst.data  output  RV_XLEN  GPR write data
chk_r1_addr  input  RV_GPR_AW  source-1 register to check
chk_r1_busy  output  1  source-1 has a pending write
chk_r2_addr  input  RV_GPR_AW  source-2 register to check
chk_r2_busy  output  1  source-2 has a pending write
cnt  output  CW  current occupancy
empty  output  1  cnt == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: wr_ptr, rd_ptr and cnt are cleared to 0. Entry valid bits are cleared. Entry payloads are not reset.
- Outputs while rst is high or immediately after reset:
  - gpr_w_mst.wen = 0, gpr_w_mst.addr = 0, gpr_w_mst.data = 0.
  - alu_rdy = lsu_rdy = 0 while rst is high.
  - chk_*_busy = 0, cnt = 0, empty = 1.
- A reset asserted mid-operation discards all queued entries in that cycle. No write is issued on the cycle rst is high.
- Storage: DEPTH entries of {rd, data}. Pointers wrap modulo DEPTH (natural binary wrap). cnt ranges 0..DEPTH.
- Drain:
  - Whenever cnt != 0, gpr_w_mst.wen = 1 and addr/data = head entry. This is combinational from registered state.
  - Head pops unconditionally at the clock edge; the GPR always accepts.
  - When empty, wen = 0 and addr = data = 0.
- Free slots per cycle: free = DEPTH - cnt + (cnt != 0 ? 1 : 0). Same-cycle drain frees a slot.
- Acceptance:
  - lsu_rdy = (free >= 1).
  - alu_rdy = (free >= 2) | (free == 1 & ~lsu_vld). LSU has priority for the last slot.
  - A producer fires on vld & rdy.
- rd == 0: the result is accepted (rdy as above) but not enqueued; no slot is consumed, and the write is silently dropped. Ready is still computed from free, not from rd.
- Enqueue order: when both fire in the same cycle, the LSU entry goes to wr_ptr and the ALU entry to wr_ptr+1. The LSU result is older.
- Counter update: cnt_next = cnt + enq_count - (cnt != 0). enq_count is 0..2 and excludes rd==0 results.
- Latency: a result accepted at edge N appears on the GPR write port in cycle N+1 at the earliest and is committed at edge N+1.
- Busy lookup: chk_rX_busy = 1 iff chk_rX_addr != 0 and any valid queued entry (head included) has rd == chk_rX_addr.
  - Busy is combinational from registered state.
  - Results accepted in the current cycle do not set busy until the next cycle.
  - The head being written this cycle still reports busy, because the GPR read this cycle is stale.
- Duplicate destinations in the queue are legal. They are written in FIFO order, so the last write wins.

Test Plan:
- Reset/idle: hold rst for 3 cycles with alu_vld = lsu_vld = 1 -> alu_rdy = lsu_rdy = 0, wen = 0, cnt = 0, empty = 1, both busy = 0.
- Single ALU result: alu rd = 5, data = 0x1234 at edge N -> cycle N+1 wen = 1, addr = 5, data = 0x1234; chk_r1_addr = 5 gives busy = 1 in cycle N+1; busy = 0 in cycle N+2.
- Dual issue: DEPTH = 4, empty, LSU rd = 3 / 0xAAAA and ALU rd = 3 / 0xBBBB in the same cycle -> cnt = 2; writes to x3 are 0xAAAA then 0xBBBB in consecutive cycles; final x3 = 0xBBBB.
- Full arbitration: fill to cnt = 4 with no new input -> free = 1. Both vld -> lsu_rdy = 1, alu_rdy = 0; LSU enqueued, cnt stays 4. Next cycle ALU alone -> alu_rdy = 1.
- x0 drop: ALU rd = 0, data = 0xFFFF with queue empty -> alu_rdy = 1, cnt stays 0, no wen; chk_r2_addr = 0 -> busy = 0.
- Reset mid-stream: cnt = 3, assert rst for 1 cycle -> next cycle cnt = 0, wen = 0, busy = 0; the three entries are never written.
